// File: rtl/pipelined_bypass_subtractor_pkg.sv
// rtl/pipelined_bypass_subtractor_pkg.sv - shared constants and flag helper for the pipelined bypass subtractor
package pipelined_bypass_subtractor_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int BLOCK_DEF = 4;
  localparam int HALF      = WIDTH_DEF / 2;
  localparam int NBLK_HALF = HALF / BLOCK_DEF;

  // Signed overflow: carry into the MSB disagrees with carry out of the MSB
  function automatic logic ovf_flag(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/bypass_sub_block.sv
// rtl/bypass_sub_block.sv - BLOCK-bit ripple adder with carry-skip mux on the block carry-out
module bypass_sub_block
  import pipelined_bypass_subtractor_pkg::*;
#(
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] bc,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [BLOCK:0] rc;
  logic           p;

  assign rc[0] = cin;

  // Sum bits always come from the ripple; only the block carry-out may skip
  for (genvar i = 0; i < BLOCK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (bc[i]),
      .ci (rc[i]),
      .s  (s[i]),
      .co (rc[i+1])
    );
  end

  assign p        = &(a ^ bc);
  assign cout     = p ? cin : rc[BLOCK];
  assign c_msb_in = rc[BLOCK-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_bypass_subtractor.sv
// rtl/pipelined_bypass_subtractor.sv - two-stage carry-bypass subtractor D = A - B - Bin with valid/ready
module pipelined_bypass_subtractor
  import pipelined_bypass_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             overFlow,
  output logic             zero
);

  localparam int HW   = WIDTH / 2;
  localparam int NBLK = HW / BLOCK;

  // Stage 1 registers: low difference, carry into the high half, high operands
  logic          s1_valid;
  logic [HW-1:0] s1_diff;
  logic          s1_carry;
  logic [HW-1:0] s1_a;
  logic [HW-1:0] s1_bc;

  logic          load_out;
  logic          accept;

  logic [HW-1:0] bc_lo;
  logic [HW-1:0] diff_lo;
  logic [NBLK:0] c_lo;
  logic [NBLK-1:0] msb_lo;

  logic [HW-1:0] diff_hi;
  logic [NBLK:0] c_hi;
  logic [NBLK-1:0] msb_hi;

  logic          unused_msb;

  assign load_out = !out_valid || out_ready;
  assign in_ready = !s1_valid || load_out;
  assign accept   = in_valid && in_ready;

  // Low half: A + ~B + ~Bin across the lower skip blocks
  assign bc_lo   = ~B[HW-1:0];
  assign c_lo[0] = ~Bin;

  for (genvar k = 0; k < NBLK; k++) begin : g_lo
    bypass_sub_block #(.BLOCK(BLOCK)) u_blk (
      .a        (A[k*BLOCK +: BLOCK]),
      .bc       (bc_lo[k*BLOCK +: BLOCK]),
      .cin      (c_lo[k]),
      .s        (diff_lo[k*BLOCK +: BLOCK]),
      .cout     (c_lo[k+1]),
      .c_msb_in (msb_lo[k])
    );
  end

  // High half: continues the chain from the registered mid carry
  assign c_hi[0] = s1_carry;

  for (genvar k = 0; k < NBLK; k++) begin : g_hi
    bypass_sub_block #(.BLOCK(BLOCK)) u_blk (
      .a        (s1_a[k*BLOCK +: BLOCK]),
      .bc       (s1_bc[k*BLOCK +: BLOCK]),
      .cin      (c_hi[k]),
      .s        (diff_hi[k*BLOCK +: BLOCK]),
      .cout     (c_hi[k+1]),
      .c_msb_in (msb_hi[k])
    );
  end

  // Only the top block's carry into its MSB feeds the overflow flag
  assign unused_msb = ^{msb_lo, msb_hi[NBLK-2:0]};

  // Stage 1 loads whenever it is vacating; valid follows in_valid, data only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_carry <= 1'b0;
      s1_a     <= '0;
      s1_bc    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_diff  <= diff_lo;
        s1_carry <= c_lo[NBLK];
        s1_a     <= A[WIDTH-1:HW];
        s1_bc    <= ~B[WIDTH-1:HW];
      end
    end
  end

  // Output stage loads when empty or being drained; result held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      D         <= '0;
      Bout      <= 1'b0;
      overFlow  <= 1'b0;
      zero      <= 1'b0;
    end else if (load_out) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        D        <= {diff_hi, s1_diff};
        Bout     <= ~c_hi[NBLK];
        overFlow <= ovf_flag(msb_hi[NBLK-1], c_hi[NBLK]);
        zero     <= ({diff_hi, s1_diff} == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_bypass_subtractor.sv
// tb/tb_pipelined_bypass_subtractor.sv - directed self-checking bench for pipelined_bypass_subtractor
module tb_pipelined_bypass_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        Bout;
  logic        overFlow;
  logic        zero;

  int tests;
  int fails;

  pipelined_bypass_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .overFlow  (overFlow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand set, then sample after the accepting edge and after the next one
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       output logic early_valid, output logic late_valid,
                       output logic [31:0] d, output logic bo, output logic ov, output logic z);
    @(negedge clk);
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    early_valid = out_valid;
    @(negedge clk);
    late_valid = out_valid;
    d = D; bo = Bout; ov = overFlow; z = zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; A = 32'd5; B = 32'd3; Bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || D !== 32'd0 || Bout !== 1'b0 || overFlow !== 1'b0 || zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b D=%h Bout=%b ovf=%b zero=%b, want all zero",
               out_valid, D, Bout, overFlow, zero);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input logic [31:0] ed, input logic eb,
                           input logic eo, input logic ez);
    logic ev, lv, bo, ov, z;
    logic [31:0] d;
    issue(a, b, bin, ev, lv, d, bo, ov, z);
    tests++;
    if (ev !== 1'b0 || lv !== 1'b1) begin
      fails++;
      $display("FAIL %s_latency: got valid after 1 edge=%b after 2 edges=%b, want 0/1", name, ev, lv);
    end
    tests++;
    if (d !== ed || bo !== eb || ov !== eo || z !== ez) begin
      fails++;
      $display("FAIL %s: got D=%h Bout=%b ovf=%b zero=%b, want D=%h Bout=%b ovf=%b zero=%b",
               name, d, bo, ov, z, ed, eb, eo, ez);
    end
  endtask

  task automatic test_basic();
    check_vec("basic", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    check_vec("basic_bin", 32'd100, 32'd40, 1'b1, 32'd59, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_borrow();
    check_vec("borrow", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check_vec("borrow_mid", 32'h0001_0000, 32'd1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    check_vec("ovf_neg", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    check_vec("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_bypass_chain();
    check_vec("bypass_bin1", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check_vec("bypass_bin0", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    int out_cycle [$];
    int idx;
    logic fire_in, fire_out;
    @(negedge clk);
    out_ready = 1'b0; Bin = 1'b0; B = 32'd1;
    A = 32'd10; in_valid = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready0: got in_ready=%b, want 1", in_ready);
    end
    @(negedge clk);
    A = 32'd20;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready1: got in_ready=%b, want 1", in_ready);
    end
    @(negedge clk);
    A = 32'd30;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || D !== 32'd9) begin
        fails++;
        $display("FAIL bp_hold%0d: got in_ready=%b out_valid=%b D=%0d, want 0/1/9",
                 c, in_ready, out_valid, D);
      end
      if (c == 2) A = 32'hDEAD_BEEF;
      if (c == 3) A = 32'd30;
      @(negedge clk);
    end
    out_ready = 1'b1;
    idx = 2;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) begin
        A = 32'd10 * (idx + 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        got.push_back(D);
        out_cycle.push_back(c);
      end
      if (fire_in) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (got.size() != 4) begin
      fails++;
      $display("FAIL bp_count: got %0d results, want 4", got.size());
    end else begin
      tests++;
      if (got[0] !== 32'd9 || got[1] !== 32'd19 || got[2] !== 32'd29 || got[3] !== 32'd39) begin
        fails++;
        $display("FAIL bp_order: got %0d,%0d,%0d,%0d, want 9,19,29,39", got[0], got[1], got[2], got[3]);
      end
      tests++;
      if (out_cycle[3] - out_cycle[0] != 3) begin
        fails++;
        $display("FAIL bp_rate: got first/last result cycles %0d/%0d, want 3 apart",
                 out_cycle[0], out_cycle[3]);
      end
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: got out_valid=%b after drain, want 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    @(negedge clk);
    out_ready = 1'b1; B = 32'd1; Bin = 1'b0;
    A = 32'd100; in_valid = 1'b1;
    @(negedge clk);
    A = 32'd200;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1 || D !== 32'd99) begin
      fails++;
      $display("FAIL mr_inflight: got out_valid=%b D=%0d, want 1/99", out_valid, D);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || D !== 32'd0) begin
      fails++;
      $display("FAIL mr_async: got out_valid=%b D=%0d, want 0/0", out_valid, D);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL mr_discard: got %0d valid cycles after reset, want 0", seen);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_bypass_chain();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
